tcdm_to_apb_bridge: RTL and testbench

Protocol bridge directly upstream of the peripheral APB demultiplexer. Accepts single-word requests from the SoC interconnect (TCDM-style req/gnt/r_valid) and issues them as APB3 transfers on one APB master port. That port feeds the peripheral bus slave port. One outstanding transfer at a time; APB wait states and PSLVERR are carried back as response latency and error opcode.

---
 rtl/tcdm_to_apb_bridge.sv | 99 +++++++++
 tb/tb_tcdm_to_apb_bridge.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/tcdm_to_apb_bridge.sv
// TCDM (req/gnt/r_valid) to APB3 bridge, one outstanding transfer.
// Optional ACCESS timeout abort enabled by defining APB_BRIDGE_TIMEOUT_EN.
module tcdm_to_apb_bridge #(
    parameter int APB_ADDR_WIDTH = 32,
    parameter int APB_DATA_WIDTH = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      req_i,
    input  logic [APB_ADDR_WIDTH-1:0] add_i,
    input  logic                      wen_i,
    input  logic [APB_DATA_WIDTH-1:0] wdata_i,
    output logic                      gnt_o,
    output logic                      r_valid_o,
    output logic [APB_DATA_WIDTH-1:0] r_rdata_o,
    output logic                      r_opc_o,
    output logic [APB_ADDR_WIDTH-1:0] paddr_o,
    output logic [APB_DATA_WIDTH-1:0] pwdata_o,
    output logic                      pwrite_o,
    output logic                      psel_o,
    output logic                      penable_o,
    input  logic [APB_DATA_WIDTH-1:0] prdata_i,
    input  logic                      pready_i,
    input  logic                      pslverr_i
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETUP  = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;
    localparam logic [1:0] RESP   = 2'd3;

    localparam logic [APB_ADDR_WIDTH-1:0] WORD_MASK = ~APB_ADDR_WIDTH'(3);

    logic [1:0] state;

    // APB control and response valid decode straight from the state register
    assign gnt_o     = req_i && (state == IDLE);
    assign psel_o    = (state == SETUP) || (state == ACCESS);
    assign penable_o = (state == ACCESS);
    assign r_valid_o = (state == RESP);

`ifdef APB_BRIDGE_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [APB_DATA_WIDTH-1:0] TIMEOUT_DATA = APB_DATA_WIDTH'(32'hBADACCE5);

    logic [CNT_W-1:0] wait_cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wait_cnt <= '0;
        end else if (state == IDLE && req_i) begin
            wait_cnt <= '0;
        end else if (state == ACCESS && !pready_i && wait_cnt != CNT_W'(TIMEOUT_CYCLES)) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state     <= IDLE;
            paddr_o   <= '0;
            pwdata_o  <= '0;
            pwrite_o  <= 1'b0;
            r_rdata_o <= '0;
            r_opc_o   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_i) begin
                        paddr_o  <= add_i & WORD_MASK;
                        pwrite_o <= ~wen_i;
                        pwdata_o <= wdata_i;
                        state    <= SETUP;
                    end
                end
                SETUP: state <= ACCESS;
                ACCESS: begin
                    if (pready_i) begin
                        r_rdata_o <= pwrite_o ? '0 : prdata_i;
                        r_opc_o   <= pslverr_i;
                        state     <= RESP;
                    end
`ifdef APB_BRIDGE_TIMEOUT_EN
                    // Counter saturated and slave still stalling: abort with error
                    else if (wait_cnt == CNT_W'(TIMEOUT_CYCLES)) begin
                        r_rdata_o <= TIMEOUT_DATA;
                        r_opc_o   <= 1'b1;
                        state     <= RESP;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tcdm_to_apb_bridge.sv
// Directed table-driven bench for tcdm_to_apb_bridge; one table row per clock cycle.
module tb_tcdm_to_apb_bridge;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req, wen, pready, pslverr;
    logic [31:0] add, wdata, prdata;
    logic        gnt, r_valid, r_opc, pwrite, psel, penable;
    logic [31:0] r_rdata, paddr, pwdata;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    tcdm_to_apb_bridge #(
        .APB_ADDR_WIDTH(32),
        .APB_DATA_WIDTH(32),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_i(req), .add_i(add), .wen_i(wen), .wdata_i(wdata),
        .gnt_o(gnt), .r_valid_o(r_valid), .r_rdata_o(r_rdata), .r_opc_o(r_opc),
        .paddr_o(paddr), .pwdata_o(pwdata), .pwrite_o(pwrite),
        .psel_o(psel), .penable_o(penable),
        .prdata_i(prdata), .pready_i(pready), .pslverr_i(pslverr)
    );

    typedef struct {
        logic        req, wen;
        logic [31:0] addr, wdata;
        logic        pready, err;
        logic [31:0] prdata;
        logic        gnt, psel, pen, rv, pwrite;
        logic [31:0] paddr, pwdata, rdata;
        logic        opc;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add_row(input logic r, w, input logic [31:0] a, wd, input logic rdy, e,
                           input logic [31:0] prd, input logic g, ps, pe, v, pw,
                           input logic [31:0] pa, pwd, rd, input logic op);
        vec_t x;
        x.req = r; x.wen = w; x.addr = a; x.wdata = wd; x.pready = rdy; x.err = e;
        x.prdata = prd; x.gnt = g; x.psel = ps; x.pen = pe; x.rv = v; x.pwrite = pw;
        x.paddr = pa; x.pwdata = pwd; x.rdata = rd; x.opc = op;
        vecs.push_back(x);
    endtask

    task automatic run_vecs(input string tag);
        foreach (vecs[i]) begin
            @(negedge clk);
            req = vecs[i].req; wen = vecs[i].wen; add = vecs[i].addr; wdata = vecs[i].wdata;
            pready = vecs[i].pready; pslverr = vecs[i].err; prdata = vecs[i].prdata;
            #1;
            chk($sformatf("%s[%0d] gnt/psel/penable/r_valid", tag, i), {28'd0, gnt, psel, penable, r_valid},
                {28'd0, vecs[i].gnt, vecs[i].psel, vecs[i].pen, vecs[i].rv});
            if (vecs[i].psel) begin
                chk($sformatf("%s[%0d] paddr", tag, i), paddr, vecs[i].paddr);
                chk($sformatf("%s[%0d] pwrite", tag, i), {31'd0, pwrite}, {31'd0, vecs[i].pwrite});
                chk($sformatf("%s[%0d] pwdata", tag, i), pwdata, vecs[i].pwdata);
            end
            if (vecs[i].rv) begin
                chk($sformatf("%s[%0d] r_rdata", tag, i), r_rdata, vecs[i].rdata);
                chk($sformatf("%s[%0d] r_opc", tag, i), {31'd0, r_opc}, {31'd0, vecs[i].opc});
            end
        end
        vecs.delete();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " psel/penable/r_valid/r_opc/pwrite"},
            {27'd0, psel, penable, r_valid, r_opc, pwrite}, 32'd0);
        chk({tag, " paddr"}, paddr, 32'd0);
        chk({tag, " pwdata"}, pwdata, 32'd0);
        chk({tag, " r_rdata"}, r_rdata, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; req = 1'b0; wen = 1'b0; add = '0; wdata = '0;
        pready = 1'b0; pslverr = 1'b0; prdata = '0;
        #12;
        chk_reset_outputs("reset");
        chk("reset gnt idle req=0", {31'd0, gnt}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Zero-wait read: address low bits dropped
        //      req wen addr          wdata  rdy err prdata         g ps pe rv pw paddr          pwdata rdata          opc
        add_row(1, 1, 32'h1A10_3006, 32'h0, 1, 0, 32'h1234_5678, 1, 0, 0, 0, 0, 32'h0,         32'h0, 32'h0,         0);
        add_row(0, 1, 32'h0,         32'h0, 1, 0, 32'h1234_5678, 0, 1, 0, 0, 0, 32'h1A10_3004, 32'h0, 32'h0,         0);
        add_row(0, 1, 32'h0,         32'h0, 1, 0, 32'h1234_5678, 0, 1, 1, 0, 0, 32'h1A10_3004, 32'h0, 32'h0,         0);
        add_row(0, 1, 32'h0,         32'h0, 1, 0, 32'h1234_5678, 0, 0, 0, 1, 0, 32'h0,         32'h0, 32'h1234_5678, 0);
        add_row(0, 1, 32'h0,         32'h0, 1, 0, 32'h0,         0, 0, 0, 0, 0, 32'h0,         32'h0, 32'h0,         0);
        run_vecs("rd0");

        // Write with 3 wait states; read data bus must not leak into r_rdata
        add_row(1, 0, 32'h0000_0013, 32'hCAFE_F00D, 0, 0, 32'hFFFF_FFFF, 1, 0, 0, 0, 0, 32'h0,  32'h0,         32'h0, 0);
        add_row(0, 0, 32'h0,         32'h0,         1, 0, 32'hFFFF_FFFF, 0, 1, 0, 0, 1, 32'h10, 32'hCAFE_F00D, 32'h0, 0);
        add_row(0, 0, 32'h0,         32'h0,         0, 0, 32'hFFFF_FFFF, 0, 1, 1, 0, 1, 32'h10, 32'hCAFE_F00D, 32'h0, 0);
        add_row(0, 0, 32'h0,         32'h0,         0, 0, 32'hFFFF_FFFF, 0, 1, 1, 0, 1, 32'h10, 32'hCAFE_F00D, 32'h0, 0);
        add_row(0, 0, 32'h0,         32'h0,         0, 0, 32'hFFFF_FFFF, 0, 1, 1, 0, 1, 32'h10, 32'hCAFE_F00D, 32'h0, 0);
        add_row(0, 0, 32'h0,         32'h0,         1, 0, 32'hFFFF_FFFF, 0, 1, 1, 0, 1, 32'h10, 32'hCAFE_F00D, 32'h0, 0);
        add_row(0, 0, 32'h0,         32'h0,         1, 0, 32'hFFFF_FFFF, 0, 0, 0, 1, 0, 32'h0,  32'h0,         32'h0, 0);
        run_vecs("wr3");

        // Slave error on read: exactly one response pulse
        add_row(1, 1, 32'h0000_0040, 32'h0, 1, 1, 32'hDEAD_0000, 1, 0, 0, 0, 0, 32'h0,  32'h0, 32'h0,         0);
        add_row(0, 1, 32'h0,         32'h0, 1, 1, 32'hDEAD_0000, 0, 1, 0, 0, 0, 32'h40, 32'h0, 32'h0,         0);
        add_row(0, 1, 32'h0,         32'h0, 1, 1, 32'hDEAD_0000, 0, 1, 1, 0, 0, 32'h40, 32'h0, 32'h0,         0);
        add_row(0, 1, 32'h0,         32'h0, 1, 1, 32'hDEAD_0000, 0, 0, 0, 1, 0, 32'h0,  32'h0, 32'hDEAD_0000, 1);
        add_row(0, 1, 32'h0,         32'h0, 1, 1, 32'hDEAD_0000, 0, 0, 0, 0, 0, 32'h0,  32'h0, 32'h0,         0);
        run_vecs("err");

        // Back-to-back reads with req held: grants only in cycles 0 and 4
        add_row(1, 1, 32'h0000_0100, 32'h0, 1, 0, 32'h0,         1, 0, 0, 0, 0, 32'h0,   32'h0, 32'h0,         0);
        add_row(1, 1, 32'h0000_0100, 32'h0, 1, 0, 32'h0,         0, 1, 0, 0, 0, 32'h100, 32'h0, 32'h0,         0);
        add_row(1, 1, 32'h0000_0100, 32'h0, 1, 0, 32'h1111_1111, 0, 1, 1, 0, 0, 32'h100, 32'h0, 32'h0,         0);
        add_row(1, 1, 32'h0000_0100, 32'h0, 1, 0, 32'h0,         0, 0, 0, 1, 0, 32'h0,   32'h0, 32'h1111_1111, 0);
        add_row(1, 1, 32'h0000_0205, 32'h0, 1, 0, 32'h0,         1, 0, 0, 0, 0, 32'h0,   32'h0, 32'h0,         0);
        add_row(0, 1, 32'h0,         32'h0, 1, 0, 32'h0,         0, 1, 0, 0, 0, 32'h204, 32'h0, 32'h0,         0);
        add_row(0, 1, 32'h0,         32'h0, 1, 0, 32'h2222_2222, 0, 1, 1, 0, 0, 32'h204, 32'h0, 32'h0,         0);
        add_row(0, 1, 32'h0,         32'h0, 1, 0, 32'h0,         0, 0, 0, 1, 0, 32'h0,   32'h0, 32'h2222_2222, 0);
        run_vecs("b2b");

        // Reset during an ACCESS wait state drops the transfer
        add_row(1, 1, 32'h0000_0080, 32'h0, 0, 0, 32'h0, 1, 0, 0, 0, 0, 32'h0,  32'h0, 32'h0, 0);
        add_row(0, 1, 32'h0,         32'h0, 0, 0, 32'h0, 0, 1, 0, 0, 0, 32'h80, 32'h0, 32'h0, 0);
        add_row(0, 1, 32'h0,         32'h0, 0, 0, 32'h0, 0, 1, 1, 0, 0, 32'h80, 32'h0, 32'h0, 0);
        run_vecs("rst_pre");
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("rst_mid");
        @(negedge clk);
        rst_n = 1'b1;
        pready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk($sformatf("rst_post[%0d] psel/r_valid", i), {30'd0, psel, r_valid}, 32'd0);
        end
        add_row(1, 1, 32'h0000_0084, 32'h0, 1, 0, 32'h5A5A_5A5A, 1, 0, 0, 0, 0, 32'h0,  32'h0, 32'h0,         0);
        add_row(0, 1, 32'h0,         32'h0, 1, 0, 32'h5A5A_5A5A, 0, 1, 0, 0, 0, 32'h84, 32'h0, 32'h0,         0);
        add_row(0, 1, 32'h0,         32'h0, 1, 0, 32'h5A5A_5A5A, 0, 1, 1, 0, 0, 32'h84, 32'h0, 32'h0,         0);
        add_row(0, 1, 32'h0,         32'h0, 1, 0, 32'h5A5A_5A5A, 0, 0, 0, 1, 0, 32'h0,  32'h0, 32'h5A5A_5A5A, 0);
        run_vecs("rst_next");

`ifdef APB_BRIDGE_TIMEOUT_EN
        begin
            int  cyc;
            logic seen;
            seen = 1'b0;
            @(negedge clk);
            req = 1'b1; wen = 1'b1; add = 32'h0000_0300; pready = 1'b0; prdata = 32'h0;
            #1;
            chk("tmo gnt", {31'd0, gnt}, 32'd1);
            @(negedge clk);
            req = 1'b0;
            for (cyc = 0; cyc < 20 && !seen; cyc++) begin
                @(negedge clk);
                #1;
                if (r_valid) seen = 1'b1;
            end
            chk("tmo response seen", {31'd0, seen}, 32'd1);
            chk("tmo psel/penable in RESP", {30'd0, psel, penable}, 32'd0);
            chk("tmo r_opc", {31'd0, r_opc}, 32'd1);
            chk("tmo r_rdata", r_rdata, 32'hBADA_CCE5);
        end
`endif

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
